// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART command receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int         CNT_W         = 12;
  localparam int         BAUD_DIV_DEF  = 2604;
  localparam logic [7:0] CMD_GO_DEF    = 8'h47;
  localparam logic [7:0] CMD_STOP_DEF  = 8'h53;

endpackage

// File: rtl/uart_cmd_rx_sync2_hi.sv
// Two-flop synchronizer for asynchronous inputs whose idle level is high.
module sync2_hi (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  // Preset to 1 so a line that idles high never looks like an edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= 2'b11;
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that also decodes GO / STOP command bytes into pulses.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int         BAUD_DIV = BAUD_DIV_DEF,
  parameter logic [7:0] CMD_GO   = CMD_GO_DEF,
  parameter logic [7:0] CMD_STOP = CMD_STOP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovrun,
  output logic       go_pls,
  output logic       stop_pls,
  output logic [1:0] dbg_state
);

  // Handshake: rdy is a level meaning rx_data holds an unread byte; the consumer
  // pulses clr_rdy to take it. A byte landing while rdy=1 sets the sticky ovrun.

  localparam logic [CNT_W-1:0] DIV_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(BAUD_DIV / 2);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [1:0]       settle;
  logic             armed;
  logic             rx_s;
  logic             expired;

  sync2_hi u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RX),
    .q   (rx_s)
  );

  assign expired   = (cnt == '0);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      settle   <= 2'b00;
      armed    <= 1'b0;
      rx_data  <= 8'h00;
      rdy      <= 1'b0;
      ovrun    <= 1'b0;
      frm_err  <= 1'b0;
      go_pls   <= 1'b0;
      stop_pls <= 1'b0;
    end else begin
      frm_err  <= 1'b0;
      go_pls   <= 1'b0;
      stop_pls <= 1'b0;
      settle   <= {settle[0], 1'b1};
      if (clr_rdy) begin
        rdy   <= 1'b0;
        ovrun <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          cnt <= DIV_HALF;
          // After reset, only arm once the synchronizer carries real line data that is high.
          if (settle[1] && rx_s) armed <= 1'b1;
          if (armed && !rx_s) state <= RX_START;
        end

        RX_START: begin
          if (expired) begin
            if (rx_s) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= DIV_FULL;
              bit_cnt <= 3'd0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RX_DATA: begin
          if (expired) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= DIV_FULL;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RX_STOP: begin
          if (expired) begin
            state <= RX_IDLE;
            if (rx_s) begin
              // Placed after the clr_rdy clear so a same-cycle completion wins rdy.
              rx_data  <= shreg;
              rdy      <= 1'b1;
              if (rdy && !clr_rdy) ovrun <= 1'b1;
              go_pls   <= (shreg == CMD_GO);
              stop_pls <= (shreg == CMD_STOP);
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: directed frames, expected events queued, monitor compares.
module tb_uart_cmd_rx;

  localparam int BIT = 64;

  logic       clk;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovrun;
  logic       go_pls;
  logic       stop_pls;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Expected event: {rx_data, go_pls, stop_pls, frm_err, ovrun}
  logic [11:0] exp_q[$];
  logic        rdy_q  = 1'b0;
  logic [7:0]  data_q = 8'h00;

  uart_cmd_rx #(
    .BAUD_DIV (BIT),
    .CMD_GO   (8'h47),
    .CMD_STOP (8'h53)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .clr_rdy   (clr_rdy),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .frm_err   (frm_err),
    .ovrun     (ovrun),
    .go_pls    (go_pls),
    .stop_pls  (stop_pls),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_evt(input logic [7:0] d, input logic g, input logic s,
                                     input logic f, input logic o);
    exp_q.push_back({d, g, s, f, o});
  endfunction

  // Driver tasks
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge clk);
    end
    RX = stop_val;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [11:0] e;
    logic [11:0] act;
    if (!rst && (frm_err || go_pls || stop_pls || (rdy && !rdy_q) || (rx_data != data_q))) begin
      act = {rx_data, go_pls, stop_pls, frm_err, ovrun};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got {data,go,stop,frm,ov}=%h, none expected", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL event: got {data,go,stop,frm,ov}=%h expected %h", act, e);
        end
      end
    end
    rdy_q  = rdy;
    data_q = rx_data;
  end

  initial begin
    rst     = 1'b1;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_state",   dbg_state, 2'd0);
    check("reset_rx_data", rx_data,   8'h00);
    check("reset_flags",   {rdy, ovrun, frm_err, go_pls, stop_pls}, 5'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // GO command
    expect_evt(8'h47, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h47, 1'b1);
    check("go_rdy", rdy, 1'b1);
    pulse_clr();
    check("go_clr_rdy", rdy, 1'b0);

    // STOP then A5 without acknowledge -> overrun
    expect_evt(8'h53, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h53, 1'b1);
    expect_evt(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1);
    check("ovr_rdy_ovrun", {rdy, ovrun}, 2'b11);
    check("ovr_rx_data", rx_data, 8'hA5);
    pulse_clr();
    check("ovr_clr", {rdy, ovrun}, 2'b00);

    // Start glitch shorter than half a bit
    RX = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    repeat (BIT) @(negedge clk);
    check("glitch_state", dbg_state, 2'd0);
    check("glitch_flags", {rdy, frm_err, go_pls, stop_pls}, 4'b0);

    // Framing error on a GO byte: rx_data keeps A5
    expect_evt(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h47, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("frm_rdy", rdy, 1'b0);

    // Reset in the middle of DATA, line still low on release
    RX = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check("mid_data_state", dbg_state, 2'd2);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    expect_evt(8'h53, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h53, 1'b1);
    check("after_rst_rx_data", rx_data, 8'h53);
    pulse_clr();

    // Back-to-back 00, FF with a one-bit gap; acknowledge coincides with FF completion
    expect_evt(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1);
    repeat (BIT) @(negedge clk);
    expect_evt(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        int waited;
        waited = 0;
        while (dbg_state != 2'd3 && waited < 2000) begin
          @(negedge clk);
          waited++;
        end
        if (dbg_state != 2'd3) begin
          check("wait_stop_timeout", dbg_state, 2'd3);
        end else begin
          repeat (BIT) @(negedge clk);
          clr_rdy = 1'b1;
          @(negedge clk);
          clr_rdy = 1'b0;
          check("coincident_clr", {rdy, ovrun}, 2'b10);
        end
      end
    join
    check("b2b_rx_data", rx_data, 8'hFF);

    repeat (2 * BIT) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per bit (50 MHz / 19200 baud).
REQ-002 Parameter CMD_GO, default 8'h47, byte that raises go.
REQ-003 Parameter CMD_STOP, default 8'h53, byte that raises stop.
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high; the block has one clock.
REQ-006 Port RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 Port clr_rdy  input  1  consumer acknowledge; clears rdy.
REQ-008 Port rx_data  output  8  last correctly framed byte.
REQ-009 Port rdy  output  1  level; a new byte is held in rx_data.
REQ-010 Port frm_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-011 Port ovrun  output  1  sticky; a byte completed while rdy was still set; cleared by clr_rdy.
REQ-012 Port go_pls  output  1  one-cycle pulse on an accepted CMD_GO byte.
REQ-013 Port stop_pls  output  1  one-cycle pulse on an accepted CMD_STOP byte.

Function
REQ-014 RX shall pass through a two-flop synchronizer; both flops preset to 1; all decisions use the second flop.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on synchronized RX low; the baud counter loads BAUD_DIV/2.
REQ-017 START: when the counter expires, RX high -> IDLE (glitch rejected, no outputs); RX low -> DATA, counter loads BAUD_DIV.
REQ-018 DATA: sample on each counter expiry (mid-bit); shift right into an 8-bit register; 3-bit bit count; after the 8th sample -> STOP.
REQ-019 STOP: sample at mid-bit. If high: rx_data <= shift register, rdy <= 1, -> IDLE. If low: frm_err pulses, rx_data and rdy are unchanged, -> IDLE.
REQ-020 IDLE is entered at mid-stop-bit; the next start edge is accepted from the following cycle.
REQ-021 Byte latency: rdy rises exactly 1 cycle after the mid-stop-bit sample.
REQ-022 If a byte completes while rdy=1: ovrun <= 1, rx_data is overwritten, rdy stays 1.
REQ-023 clr_rdy has priority over a same-cycle completion: rdy stays 1 (new byte), ovrun is not set.
REQ-024 go_pls/stop_pls fire in the same cycle rdy is set, and only for good frames that equal CMD_GO/CMD_STOP.
REQ-025 Any other byte produces no pulse.
REQ-026 The baud counter is 12 bits, counts down, and expires at 0; it never wraps while in IDLE.

Reset
REQ-027 While rst=1: state=IDLE, rx_data=8'h00, rdy=0, ovrun=0, frm_err=0, go_pls=0, stop_pls=0, synchronizer=2'b11.
REQ-028 Reset mid-frame discards the partial byte; after release, the line must be seen high before a new start is taken.

Structure
REQ-029 Package uart_pkg holds the rx_state_t enum, the default BAUD_DIV, and the command constants 8'h47 and 8'h53.
REQ-030 The two-flop preset synchronizer shall be sub-module sync2_hi, reusable on other async inputs.

Verification
REQ-031 Send 8'h47 via UART_tx at BAUD_DIV=2604 -> rx_data=8'h47, rdy=1, one go_pls, no stop_pls.
REQ-032 Send 8'h53, then 8'hA5 without clr_rdy -> stop_pls once; rx_data=8'hA5; ovrun=1; clr_rdy clears both rdy and ovrun.
REQ-033 Drive RX low for 1000 clocks (< BAUD_DIV/2), then high -> FSM returns to IDLE; rdy, frm_err and pulses all stay 0.
REQ-034 Send a frame with stop bit forced low, data 8'h47 -> frm_err pulses 1 cycle; no go_pls; rx_data retains its prior value.
REQ-035 Assert rst mid-DATA, release, then send 8'h53 -> clean reception, stop_pls once, no residual bits.
REQ-036 Send back-to-back bytes 8'h00, 8'hFF with a one-bit gap -> both received; clr_rdy coincident with the second completion leaves rdy=1 and ovrun=0.
